and_tree_pipe: RTL and testbench

- Parametrised, pipelined N-input logic-reduction cell that generalises the fixed 4-input AND gate.
- Reduces NUM_IN words of WIDTH bits, bitwise, through a FANIN-ary tree with a register after every tree level.
- Runtime op select: AND, NAND, OR or NOR.
- Valid/ready flow control with backpressure. Used in datapath zero/all-ones detection blocks where a flat 4-input cell no longer meets timing.

---
 rtl/and_tree_pipe_pkg.sv | 43 ++++
 rtl/and_tree_pipe_stage.sv | 68 ++++++
 rtl/and_tree_pipe.sv | 98 +++++++++
 tb/tb_and_tree_pipe.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/and_tree_pipe_pkg.sv
// and_tree_pkg: mode encodings and elaboration helpers shared by the pipelined
// reduction tree (and_tree_pipe) and its per-level stage (and_tree_stage).
package and_tree_pkg;

    typedef enum logic [1:0] {
        MODE_AND  = 2'd0,
        MODE_NAND = 2'd1,
        MODE_OR   = 2'd2,
        MODE_NOR  = 2'd3
    } mode_e;

    // Tree depth needed to reduce n entries with f-input nodes, never less than one level.
    function automatic int unsigned clog_fanin(input int unsigned n, input int unsigned f);
        int unsigned lv;
        int unsigned cap;
        lv  = 0;
        cap = 1;
        for (int unsigned i = 0; i < 32; i++) begin
            if (cap < n) begin
                cap = cap * f;
                lv  = lv + 1;
            end
        end
        return (lv == 0) ? 32'd1 : lv;
    endfunction

    // Entries remaining after k levels of f-input combining (level 0 is the raw input).
    function automatic int unsigned nodes_at_level(input int unsigned n, input int unsigned f,
                                                   input int unsigned k);
        int unsigned cnt;
        cnt = n;
        for (int unsigned i = 0; i < k; i++) begin
            cnt = (cnt + f - 1) / f;
        end
        return cnt;
    endfunction

    // Padding value that leaves the base op unchanged: ones for AND, zeros for OR.
    function automatic logic base_identity(input mode_e m);
        return ~m[1];
    endfunction

endpackage

// File: rtl/and_tree_pipe_stage.sv
// and_tree_stage: one tree level -- FANIN-ary AND/OR combine with identity padding,
// followed by a valid/data/mode register that advances when downstream is ready.
module and_tree_stage
    import and_tree_pkg::*;
#(
    parameter  int unsigned N_IN  = 4,
    parameter  int unsigned WIDTH = 1,
    parameter  int unsigned FANIN = 4,
    localparam int unsigned N_OUT = (N_IN + FANIN - 1) / FANIN
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN*WIDTH-1:0]  in_data,
    input  mode_e                  in_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output mode_e                  out_mode
);

    localparam int unsigned N_PAD = N_OUT * FANIN;

    logic                   is_or;
    logic [WIDTH-1:0]       ident;
    logic [WIDTH-1:0]       node_acc;
    logic [N_PAD*WIDTH-1:0] padded;
    logic [N_OUT*WIDTH-1:0] combined;

    // The last group is filled with the identity value so it reduces like a full group.
    always_comb begin
        is_or    = in_mode[1];
        ident    = {WIDTH{base_identity(in_mode)}};
        padded   = {N_PAD{ident}};
        padded[N_IN*WIDTH-1:0] = in_data;
        combined = '0;
        node_acc = '0;
        for (int unsigned n = 0; n < N_OUT; n++) begin
            node_acc = ident;
            for (int unsigned j = 0; j < FANIN; j++) begin
                if (is_or) begin
                    node_acc = node_acc | padded[(n*FANIN + j)*WIDTH +: WIDTH];
                end else begin
                    node_acc = node_acc & padded[(n*FANIN + j)*WIDTH +: WIDTH];
                end
            end
            combined[n*WIDTH +: WIDTH] = node_acc;
        end
    end

    assign in_ready = ~out_valid | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_mode  <= MODE_AND;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= combined;
                out_mode <= in_mode;
            end
        end
    end

endmodule

// File: rtl/and_tree_pipe.sv
// and_tree_pipe: pipelined NUM_IN-word bitwise AND/NAND/OR/NOR reduction through a FANIN-ary tree.
// Define AND_TREE_PIPE_STALL_CNT_EN to add the CNT_CLR input and the saturating STALL_CNT output.
module and_tree_pipe
    import and_tree_pkg::*;
#(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned FANIN  = 4
) (
    input  logic                    CLK,
    input  logic                    RSTB,
    input  logic [NUM_IN*WIDTH-1:0] IN,
    input  logic [1:0]              MODE,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    output logic [WIDTH-1:0]        Q,
    output logic                    Q_VALID,
    input  logic                    Q_READY
`ifdef AND_TREE_PIPE_STALL_CNT_EN
    ,
    input  logic                    CNT_CLR,
    output logic [15:0]             STALL_CNT
`endif
);

    localparam int unsigned LEVELS = clog_fanin(NUM_IN, FANIN);

    // Each level keeps its own handshake nets; neighbours are reached by generate-block name
    // so the combinational ready chain never folds back onto a single vector.
    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int unsigned N_I = nodes_at_level(NUM_IN, FANIN, k);
        localparam int unsigned N_O = nodes_at_level(NUM_IN, FANIN, k + 1);

        logic               s_in_valid;
        logic               s_in_ready;
        logic [N_I*WIDTH-1:0] s_in_data;
        mode_e              s_in_mode;
        logic               s_out_valid;
        logic               s_out_ready;
        logic [N_O*WIDTH-1:0] s_out_data;
        mode_e              s_out_mode;

        if (k == 0) begin : g_src
            assign s_in_valid = IN_VALID;
            assign s_in_data  = IN;
            assign s_in_mode  = mode_e'(MODE);
        end else begin : g_src
            assign s_in_valid = g_lvl[k-1].s_out_valid;
            assign s_in_data  = g_lvl[k-1].s_out_data;
            assign s_in_mode  = g_lvl[k-1].s_out_mode;
        end

        if (k == LEVELS - 1) begin : g_snk
            assign s_out_ready = Q_READY;
        end else begin : g_snk
            assign s_out_ready = g_lvl[k+1].s_in_ready;
        end

        and_tree_stage #(
            .N_IN  (N_I),
            .WIDTH (WIDTH),
            .FANIN (FANIN)
        ) u_stage (
            .clk       (CLK),
            .rst_n     (RSTB),
            .in_valid  (s_in_valid),
            .in_ready  (s_in_ready),
            .in_data   (s_in_data),
            .in_mode   (s_in_mode),
            .out_valid (s_out_valid),
            .out_ready (s_out_ready),
            .out_data  (s_out_data),
            .out_mode  (s_out_mode)
        );
    end

    assign IN_READY = g_lvl[0].s_in_ready;
    assign Q_VALID  = g_lvl[LEVELS-1].s_out_valid;
    // NAND/NOR inversion uses the mode that travelled with the beat, not the live MODE input.
    assign Q = g_lvl[LEVELS-1].s_out_data ^ {WIDTH{g_lvl[LEVELS-1].s_out_mode[0]}};

`ifdef AND_TREE_PIPE_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            stall_cnt_q <= '0;
        end else if (CNT_CLR) begin
            stall_cnt_q <= '0;
        end else if (Q_VALID && !Q_READY && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign STALL_CNT = stall_cnt_q;
`endif

endmodule

// File: tb/tb_and_tree_pipe.sv
// tb_and_tree_pipe: table-driven and scoreboard checks of and_tree_pipe in three configurations
// (4x1 fanin 4, 6x8 fanin 4, 16x1 fanin 4); stall-counter checks when AND_TREE_PIPE_STALL_CNT_EN is set.
module tb_and_tree_pipe;
    import and_tree_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;
    int          a_qv_cnt = 0;
    always @(posedge clk) cyc++;

    // DUT A: default parameters, single level
    logic [3:0]  a_in;  logic [1:0] a_mode; logic a_valid, a_ready, a_q, a_qv, a_qr, a_exp;
    // DUT B: 6 words of 8 bits, two levels with a padded group
    logic [47:0] b_in;  logic [1:0] b_mode; logic b_valid, b_ready, b_qv, b_qr;
    logic [7:0]  b_q, b_exp;
    // DUT C: 16 single-bit words, two full levels
    logic [15:0] c_in;  logic [1:0] c_mode; logic c_valid, c_ready, c_q, c_qv, c_qr, c_exp;
`ifdef AND_TREE_PIPE_STALL_CNT_EN
    logic a_clr, b_clr, c_clr;
    logic [15:0] a_cnt, b_cnt, c_cnt;
`endif

    and_tree_pipe #(.NUM_IN(4), .WIDTH(1), .FANIN(4)) dut_a (
        .CLK(clk), .RSTB(rst_n), .IN(a_in), .MODE(a_mode), .IN_VALID(a_valid), .IN_READY(a_ready),
        .Q(a_q), .Q_VALID(a_qv), .Q_READY(a_qr)
`ifdef AND_TREE_PIPE_STALL_CNT_EN
        , .CNT_CLR(a_clr), .STALL_CNT(a_cnt)
`endif
    );

    and_tree_pipe #(.NUM_IN(6), .WIDTH(8), .FANIN(4)) dut_b (
        .CLK(clk), .RSTB(rst_n), .IN(b_in), .MODE(b_mode), .IN_VALID(b_valid), .IN_READY(b_ready),
        .Q(b_q), .Q_VALID(b_qv), .Q_READY(b_qr)
`ifdef AND_TREE_PIPE_STALL_CNT_EN
        , .CNT_CLR(b_clr), .STALL_CNT(b_cnt)
`endif
    );

    and_tree_pipe #(.NUM_IN(16), .WIDTH(1), .FANIN(4)) dut_c (
        .CLK(clk), .RSTB(rst_n), .IN(c_in), .MODE(c_mode), .IN_VALID(c_valid), .IN_READY(c_ready),
        .Q(c_q), .Q_VALID(c_qv), .Q_READY(c_qr)
`ifdef AND_TREE_PIPE_STALL_CNT_EN
        , .CNT_CLR(c_clr), .STALL_CNT(c_cnt)
`endif
    );

    typedef struct { logic [3:0]  d; logic [1:0] m; logic       q; } vec_a_t;
    typedef struct { logic [47:0] d; logic [1:0] m; logic [7:0] q; } vec_b_t;
    typedef struct { logic [15:0] d; logic [1:0] m; logic       q; } vec_c_t;

    vec_a_t tab_a[8];
    vec_b_t tab_b[6];
    vec_c_t tab_c[8];

    logic       qa[$];
    logic [7:0] qb[$];
    logic       qc[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Flat reference reduction over all six words, independent of any tree structure.
    function automatic logic [7:0] model_b(input logic [47:0] d, input logic [1:0] m);
        logic [7:0] r;
        r = m[1] ? 8'h00 : 8'hFF;
        for (int i = 0; i < 6; i++) r = m[1] ? (r | d[i*8 +: 8]) : (r & d[i*8 +: 8]);
        return m[0] ? ~r : r;
    endfunction

    task automatic send_a(input logic [3:0] d, input logic [1:0] m, input logic e);
        int unsigned guard;
        guard = 0;
        a_in = d; a_mode = m; a_exp = e; a_valid = 1'b1;
        @(negedge clk);
        while (!a_ready && guard < 200) begin @(negedge clk); guard++; end
        if (!a_ready) begin checks++; errors++; $display("FAIL a_send_timeout: IN_READY 0, required 1"); end
        @(posedge clk); #1;
        a_valid = 1'b0;
    endtask

    task automatic send_b(input logic [47:0] d, input logic [1:0] m, input logic [7:0] e);
        int unsigned guard;
        guard = 0;
        b_in = d; b_mode = m; b_exp = e; b_valid = 1'b1;
        @(negedge clk);
        while (!b_ready && guard < 200) begin @(negedge clk); guard++; end
        if (!b_ready) begin checks++; errors++; $display("FAIL b_send_timeout: IN_READY 0, required 1"); end
        @(posedge clk); #1;
        b_valid = 1'b0;
    endtask

    task automatic send_c(input logic [15:0] d, input logic [1:0] m, input logic e);
        int unsigned guard;
        guard = 0;
        c_in = d; c_mode = m; c_exp = e; c_valid = 1'b1;
        @(negedge clk);
        while (!c_ready && guard < 200) begin @(negedge clk); guard++; end
        if (!c_ready) begin checks++; errors++; $display("FAIL c_send_timeout: IN_READY 0, required 1"); end
        @(posedge clk); #1;
        c_valid = 1'b0;
    endtask

    // Scoreboards: sampled mid-cycle; a handshake seen here completes on the next rising edge.
    always @(negedge clk) if (rst_n) begin
        if (a_qv && a_qr) begin
            if (qa.size() == 0) begin checks++; errors++; $display("FAIL a_extra: unexpected Q=%0h", a_q); end
            else check("a_q", a_q, qa.pop_front());
        end else if (a_qv && qa.size() > 0) check("a_hold", a_q, qa[0]);
        if (a_valid && a_ready) qa.push_back(a_exp);
        if (a_qv) a_qv_cnt++;
    end

    always @(negedge clk) if (rst_n) begin
        if (b_qv && b_qr) begin
            if (qb.size() == 0) begin checks++; errors++; $display("FAIL b_extra: unexpected Q=%0h", b_q); end
            else check("b_q", b_q, qb.pop_front());
        end else if (b_qv && qb.size() > 0) check("b_hold", b_q, qb[0]);
        if (b_valid && b_ready) qb.push_back(b_exp);
    end

    always @(negedge clk) if (rst_n) begin
        if (c_qv && c_qr) begin
            if (qc.size() == 0) begin checks++; errors++; $display("FAIL c_extra: unexpected Q=%0h", c_q); end
            else check("c_q", c_q, qc.pop_front());
        end else if (c_qv && qc.size() > 0) check("c_hold", c_q, qc[0]);
        if (c_valid && c_ready) qc.push_back(c_exp);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        logic [47:0] bp_d[8];
        logic [1:0]  bp_m[8];
        logic [7:0]  bp_e[8];
        int unsigned c0;

        tab_a[0] = '{d: 4'b1111, m: MODE_AND,  q: 1'b1};
        tab_a[1] = '{d: 4'b1011, m: MODE_AND,  q: 1'b0};
        tab_a[2] = '{d: 4'b1111, m: MODE_NAND, q: 1'b0};
        tab_a[3] = '{d: 4'b0111, m: MODE_NAND, q: 1'b1};
        tab_a[4] = '{d: 4'b0000, m: MODE_OR,   q: 1'b0};
        tab_a[5] = '{d: 4'b0100, m: MODE_OR,   q: 1'b1};
        tab_a[6] = '{d: 4'b0000, m: MODE_NOR,  q: 1'b1};
        tab_a[7] = '{d: 4'b1000, m: MODE_NOR,  q: 1'b0};

        tab_b[0] = '{d: {8'hFE, {5{8'hFF}}},                       m: MODE_NAND, q: 8'h01};
        tab_b[1] = '{d: {6{8'hFF}},                                m: MODE_AND,  q: 8'hFF};
        tab_b[2] = '{d: {8'h00, 8'h81, {4{8'h00}}},                m: MODE_OR,   q: 8'h81};
        tab_b[3] = '{d: {6{8'h00}},                                m: MODE_NOR,  q: 8'hFF};
        tab_b[4] = '{d: {8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01}, m: MODE_NOR,  q: 8'hC0};
        tab_b[5] = '{d: {8'hFC, 8'hFF, 8'hF7, 8'hF3, 8'hF1, 8'hF0}, m: MODE_AND,  q: 8'hF0};

        tab_c[0] = '{d: 16'h0000, m: MODE_NOR,  q: 1'b1};
        tab_c[1] = '{d: 16'h8000, m: MODE_NOR,  q: 1'b0};
        tab_c[2] = '{d: 16'hFFFF, m: MODE_AND,  q: 1'b1};
        tab_c[3] = '{d: 16'hFFFE, m: MODE_AND,  q: 1'b0};
        tab_c[4] = '{d: 16'hFFFF, m: MODE_NAND, q: 1'b0};
        tab_c[5] = '{d: 16'h0100, m: MODE_OR,   q: 1'b1};
        tab_c[6] = '{d: 16'h0000, m: MODE_OR,   q: 1'b0};
        tab_c[7] = '{d: 16'h7FFF, m: MODE_NAND, q: 1'b1};

        for (int i = 0; i < 8; i++) begin
            logic [7:0] base;
            base    = 8'($urandom);
            bp_m[i] = 2'($urandom_range(0, 3));
            for (int w = 0; w < 6; w++)
                bp_d[i][w*8 +: 8] = bp_m[i][1] ? (base & 8'($urandom) & 8'($urandom))
                                               : (base | 8'($urandom) | 8'($urandom));
            bp_e[i] = model_b(bp_d[i], bp_m[i]);
        end

        a_in = '0; a_mode = '0; a_valid = 1'b0; a_qr = 1'b1; a_exp = 1'b0;
        b_in = '0; b_mode = '0; b_valid = 1'b0; b_qr = 1'b1; b_exp = '0;
        c_in = '0; c_mode = '0; c_valid = 1'b0; c_qr = 1'b1; c_exp = 1'b0;
`ifdef AND_TREE_PIPE_STALL_CNT_EN
        a_clr = 1'b0; b_clr = 1'b0; c_clr = 1'b0;
`endif

        // Reset state
        rst_n = 1'b0;
        #3;
        check("rst_a_qv", a_qv, 0); check("rst_a_q", a_q, 0);
        check("rst_b_qv", b_qv, 0); check("rst_b_q", b_q, 0);
        check("rst_c_qv", c_qv, 0); check("rst_c_q", c_q, 0);
        #9 rst_n = 1'b1;
        tick(1);
        check("rst_a_ready", a_ready, 1);
        check("rst_b_ready", b_ready, 1);
        check("rst_c_ready", c_ready, 1);

        // Single level: 1-cycle latency, Q_VALID high for exactly two beats
        a_qv_cnt = 0;
        send_a(4'b1111, MODE_AND, 1'b1);
        check("a_latency", a_qv, 1);
        send_a(4'b1011, MODE_AND, 1'b0);
        tick(4);
        check("a_qv_cycles", a_qv_cnt, 2);

        for (int i = 0; i < 8; i++) send_a(tab_a[i].d, tab_a[i].m, tab_a[i].q);
        tick(3);

        // Two levels with padding: latency 2
        send_b(tab_b[0].d, tab_b[0].m, tab_b[0].q);
        check("b_latency_1", b_qv, 0);
        tick(1);
        check("b_latency_2", b_qv, 1);
        tick(3);

        // Back-to-back table beats: one acceptance per cycle
        c0 = cyc;
        for (int i = 0; i < 6; i++) send_b(tab_b[i].d, tab_b[i].m, tab_b[i].q);
        check("b_throughput", cyc - c0, 6);
        tick(4);

        // Backpressure: Q_READY low for several cycles in the middle of an 8-beat stream
        fork
            begin
                for (int i = 0; i < 8; i++) send_b(bp_d[i], bp_m[i], bp_e[i]);
            end
            begin
                tick(3);
                b_qr = 1'b0;
                tick(4);
                check("bp_in_ready", b_ready, 0);
                check("bp_q_valid", b_qv, 1);
                tick(1);
                b_qr = 1'b1;
            end
        join
        tick(5);

        // MODE changes while stalled must not affect beats already in flight
        b_qr = 1'b0;
        send_b({6{8'h3C}}, MODE_AND,  8'h3C);
        send_b({6{8'h3C}}, MODE_NAND, 8'hC3);
        for (int i = 0; i < 4; i++) begin
            b_mode = 2'(i);
            b_in   = 48'({$urandom, $urandom});
            tick(1);
            check("b_full_ready", b_ready, 0);
        end
        b_qr = 1'b1;
        tick(4);

        // 16 inputs: latency 2 then the table
        send_c(16'h0000, MODE_NOR, 1'b1);
        check("c_latency_1", c_qv, 0);
        tick(1);
        check("c_latency_2", c_qv, 1);
        tick(2);
        for (int i = 0; i < 8; i++) send_c(tab_c[i].d, tab_c[i].m, tab_c[i].q);
        tick(4);

`ifdef AND_TREE_PIPE_STALL_CNT_EN
        a_qr = 1'b0;
        send_a(4'b1111, MODE_AND, 1'b1);
        tick(5);
        check("cnt_five", a_cnt, 16'd5);
        a_clr = 1'b1;
        tick(1);
        check("cnt_clear", a_cnt, 16'd0);
        a_clr = 1'b0;
        tick(70000);
        check("cnt_saturate", a_cnt, 16'hFFFF);
        a_qr = 1'b1;
        tick(3);
`endif

        // Reset with two beats in flight: outputs fall before the next edge, nothing stale after
        send_b({6{8'hFF}}, MODE_AND, 8'hFF);
        send_b({6{8'h5A}}, MODE_OR,  8'h5A);
        check("mid_pre_qv", b_qv, 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_qv", b_qv, 0);
        check("mid_rst_q", b_q, 0);
        qb.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick(1);
        check("mid_post_ready", b_ready, 1);
        tick(5);
        check("mid_post_qv", b_qv, 0);

        tick(6);
        check("a_drain", qa.size(), 0);
        check("b_drain", qb.size(), 0);
        check("c_drain", qc.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
